// File: rtl/button_press_classifier_if.sv
// Debounced button level in, classified one-cycle event pulses and held level out.
interface button_press_classifier_if;
  logic i_Button;
  logic o_Press;
  logic o_Release;
  logic o_Short;
  logic o_Long;
  logic o_Double;
  logic o_Held;

  modport master (
    output i_Button,
    input  o_Press, o_Release, o_Short, o_Long, o_Double, o_Held
  );

  modport slave (
    input  i_Button,
    output o_Press, o_Release, o_Short, o_Long, o_Double, o_Held
  );
endinterface

// File: rtl/button_press_classifier.sv
// Turns a clean button level into press/release edge pulses and a classified
// gesture (short, long or double press); thresholds are in clock cycles.
module button_press_classifier #(
  parameter int LONG_PRESS_CYCLES = 12500000,
  parameter int DOUBLE_GAP_CYCLES = 6250000
) (
  input logic                      i_Clk,
  input logic                      i_Rst_L,
  button_press_classifier_if.slave bus
);

  localparam int MAX_TH = (LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES) ?
                          LONG_PRESS_CYCLES : DOUBLE_GAP_CYCLES;
  localparam int CW = $clog2(MAX_TH);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(DOUBLE_GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED1,
    WAIT_GAP,
    PRESSED2,
    LONG_HOLD
  } state_t;

  state_t          stateQ, stateD;
  logic [CW-1:0]   cntQ, cntD;
  logic            prevQ;
  logic            pressQ, releaseQ, shortQ, longQ, doubleQ, heldQ;
  logic            shortD, longD, doubleD, heldD;
  logic            rise, fall;

  assign rise = bus.i_Button & ~prevQ;
  assign fall = ~bus.i_Button & prevQ;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      stateQ   <= IDLE;
      cntQ     <= '0;
      prevQ    <= 1'b0;
      pressQ   <= 1'b0;
      releaseQ <= 1'b0;
      shortQ   <= 1'b0;
      longQ    <= 1'b0;
      doubleQ  <= 1'b0;
      heldQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      prevQ    <= bus.i_Button;
      pressQ   <= rise;
      releaseQ <= fall;
      shortQ   <= shortD;
      longQ    <= longD;
      doubleQ  <= doubleD;
      heldQ    <= heldD;
    end
  end

  // Edges take priority over the timers, so a release on the long threshold
  // or a rise on the gap timeout decides the gesture.
  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    shortD  = 1'b0;
    longD   = 1'b0;
    doubleD = 1'b0;
    case (stateQ)
      IDLE: begin
        if (rise) stateD = PRESSED1;
      end
      PRESSED1: begin
        if (fall) begin
          stateD = WAIT_GAP;
        end else if (cntQ == LONG_LAST) begin
          longD  = 1'b1;
          stateD = LONG_HOLD;
        end else begin
          cntD = cntQ + CW'(1);
        end
      end
      WAIT_GAP: begin
        if (rise) begin
          doubleD = 1'b1;
          stateD  = PRESSED2;
        end else if (cntQ == GAP_LAST) begin
          shortD = 1'b1;
          stateD = IDLE;
        end else begin
          cntD = cntQ + CW'(1);
        end
      end
      PRESSED2: begin
        if (fall) stateD = IDLE;
      end
      LONG_HOLD: begin
        if (fall) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
    if (stateD != stateQ) cntD = '0;
    heldD = (stateD == LONG_HOLD);
  end

  assign bus.o_Press   = pressQ;
  assign bus.o_Release = releaseQ;
  assign bus.o_Short   = shortQ;
  assign bus.o_Long    = longQ;
  assign bus.o_Double  = doubleQ;
  assign bus.o_Held    = heldQ;

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier with LONG_PRESS_CYCLES=8, DOUBLE_GAP_CYCLES=5.
module tb_button_press_classifier;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] P    = 6'b100000;
  localparam logic [5:0] R    = 6'b010000;
  localparam logic [5:0] S    = 6'b001000;
  localparam logic [5:0] LG   = 6'b000100;
  localparam logic [5:0] D    = 6'b000010;
  localparam logic [5:0] H    = 6'b000001;

  typedef struct {
    logic       button;
    logic [5:0] expOut;
  } vec_t;

  typedef struct {
    logic [5:0] expOut;
    int         id;
  } sb_t;

  logic clock;
  logic resetN;
  int   vecCount;
  int   missCount;
  vec_t vecs[$];
  sb_t  sb[$];

  button_press_classifier_if bus ();

  button_press_classifier #(
    .LONG_PRESS_CYCLES(8),
    .DOUBLE_GAP_CYCLES(5)
  ) dut (
    .i_Clk  (clock),
    .i_Rst_L(resetN),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [5:0] actualOut();
    return {bus.o_Press, bus.o_Release, bus.o_Short,
            bus.o_Long, bus.o_Double, bus.o_Held};
  endfunction

  task automatic addVec(input logic b, input logic [5:0] e);
    vec_t v;
    v.button = b;
    v.expOut = e;
    vecs.push_back(v);
  endtask

  task automatic addN(input logic b, input int n, input logic [5:0] e);
    for (int k = 0; k < n; k++) addVec(b, e);
  endtask

  task automatic checkOutput();
    sb_t e;
    logic [5:0] got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = actualOut();
      vecCount++;
      if (got !== e.expOut) begin
        missCount++;
        $display("[TB] FAIL vec%0d outputs(press,release,short,long,double,held) got %b want %b",
                 e.id, got, e.expOut);
      end
    end
  endtask

  task automatic checkDirect(input string name, input logic [5:0] e);
    logic [5:0] got;
    got = actualOut();
    vecCount++;
    if (got !== e) begin
      missCount++;
      $display("[TB] FAIL %s outputs got %b want %b", name, got, e);
    end
  endtask

  task automatic applyStimulus(input logic b, input logic [5:0] e, input int id);
    sb_t s;
    @(negedge clock);
    checkOutput();
    bus.i_Button = b;
    s.expOut = e;
    s.id     = id;
    sb.push_back(s);
  endtask

  task automatic drain();
    @(negedge clock);
    checkOutput();
  endtask

  task automatic assertReset(input string name);
    drain();
    @(negedge clock);
    resetN = 1'b0;
    #1;
    checkDirect(name, NONE);
  endtask

  task automatic releaseReset(input logic b, input logic [5:0] e, input int id);
    sb_t s;
    @(negedge clock);
    resetN       = 1'b1;
    bus.i_Button = b;
    s.expOut = e;
    s.id     = id;
    sb.push_back(s);
  endtask

  initial begin
    vecCount     = 0;
    missCount    = 0;
    resetN       = 1'b0;
    bus.i_Button = 1'b0;

    addN(0, 2, NONE);
    // short press
    addVec(1, P); addN(1, 2, NONE); addVec(0, R); addN(0, 4, NONE); addVec(0, S); addN(0, 2, NONE);
    // long press, 20 cycles high
    addVec(1, P); addN(1, 7, NONE); addVec(1, LG | H); addN(1, 11, H); addVec(0, R); addN(0, 7, NONE);
    // double press
    addVec(1, P); addN(1, 2, NONE); addVec(0, R); addVec(0, NONE);
    addVec(1, P | D); addN(1, 2, NONE); addVec(0, R); addN(0, 7, NONE);
    // double press with the second press held 20 cycles
    addVec(1, P); addN(1, 2, NONE); addVec(0, R); addVec(0, NONE);
    addVec(1, P | D); addN(1, 19, NONE); addVec(0, R); addN(0, 7, NONE);
    // release sampled on the long threshold edge
    addVec(1, P); addN(1, 7, NONE); addVec(0, R); addN(0, 4, NONE); addVec(0, S); addN(0, 2, NONE);
    // second rise on the gap timeout edge
    addVec(1, P); addN(1, 2, NONE); addVec(0, R); addN(0, 4, NONE);
    addVec(1, P | D); addVec(1, NONE); addVec(0, R); addN(0, 7, NONE);
    // second rise one edge after the timeout is a fresh first press
    addVec(1, P); addN(1, 2, NONE); addVec(0, R); addN(0, 4, NONE); addVec(0, S);
    addVec(1, P); addN(1, 7, NONE); addVec(1, LG | H); addVec(1, H); addVec(0, R); addN(0, 7, NONE);

    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      bus.i_Button = ~bus.i_Button;
      #1;
      checkDirect("resetHeldToggle", NONE);
    end
    @(negedge clock);
    bus.i_Button = 1'b0;
    @(negedge clock);
    resetN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i].button, vecs[i].expOut, i);
    drain();

    // reset while in LONG_HOLD, button high across reset release
    applyStimulus(1, P, 1000);
    for (int i = 0; i < 7; i++) applyStimulus(1, NONE, 1001 + i);
    applyStimulus(1, LG | H, 1008);
    for (int i = 0; i < 3; i++) applyStimulus(1, H, 1009 + i);
    assertReset("resetInLongHold");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus.i_Button = ~bus.i_Button;
      #1;
      checkDirect("resetLowToggle", NONE);
    end
    @(negedge clock);
    bus.i_Button = 1'b1;
    releaseReset(1, P, 1100);
    for (int i = 0; i < 7; i++) applyStimulus(1, NONE, 1101 + i);
    applyStimulus(1, LG | H, 1108);
    applyStimulus(0, R, 1109);
    for (int i = 0; i < 7; i++) applyStimulus(0, NONE, 1110 + i);
    drain();

    // reset four cycles into a press, then a short press as a first press
    applyStimulus(1, P, 1200);
    for (int i = 0; i < 3; i++) applyStimulus(1, NONE, 1201 + i);
    assertReset("resetMidPress");
    @(negedge clock);
    bus.i_Button = 1'b0;
    @(negedge clock);
    releaseReset(0, NONE, 1300);
    for (int i = 0; i < 8; i++) applyStimulus(0, NONE, 1301 + i);
    applyStimulus(1, P, 1310);
    applyStimulus(1, NONE, 1311);
    applyStimulus(1, NONE, 1312);
    applyStimulus(0, R, 1313);
    for (int i = 0; i < 4; i++) applyStimulus(0, NONE, 1314 + i);
    applyStimulus(0, S, 1318);
    drain();

    // reset during the gap: no pending short is reported
    applyStimulus(1, P, 1400);
    applyStimulus(1, NONE, 1401);
    applyStimulus(1, NONE, 1402);
    applyStimulus(0, R, 1403);
    applyStimulus(0, NONE, 1404);
    assertReset("resetMidGap");
    releaseReset(0, NONE, 1500);
    for (int i = 0; i < 7; i++) applyStimulus(0, NONE, 1501 + i);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/button_press_classifier.md
# button_press_classifier

Sits directly downstream of the debouncer: takes its clean, clock-synchronous button level and turns it into one-cycle event pulses for the user logic. Events are press and release edges, plus a classified gesture: short press, long press or double press. Held state is reported as a level. Thresholds are in clock cycles and set by parameters (defaults assume the 25 MHz Go Board clock).

## Interface
- LONG_PRESS_CYCLES, 12500000: hold time that makes a long press (0.5 s); must be ≥ 2
- DOUBLE_GAP_CYCLES, 6250000: maximum release-to-second-press gap for a double press (0.25 s); must be ≥ 2
- Counter width is derived internally as $clog2 of the larger threshold; it is not a parameter.

- i_Clk  in  1  system clock
- i_Rst_L  in  1  reset; one clock; reset is asynchronous and active-low
- i_Button  in  1  debounced button level (o_DebouncedSignal of the debouncer), already synchronous to i_Clk
- o_Press  out  1  one-cycle pulse on every rising edge of i_Button
- o_Release  out  1  one-cycle pulse on every falling edge of i_Button
- o_Short  out  1  one-cycle pulse: single press completed, no second press within the gap
- o_Long  out  1  one-cycle pulse: first press held LONG_PRESS_CYCLES
- o_Double  out  1  one-cycle pulse: second press started within the gap
- o_Held  out  1  level, high while in LONG_HOLD

## Operation
- Edge detect:
  - r_Prev holds i_Button from the previous edge; it resets to 0.
  - rise = i_Button & ~r_Prev; fall = ~i_Button & r_Prev.
  - A button already high at reset release produces o_Press on the first edge.
- FSM states are IDLE, PRESSED1, WAIT_GAP, PRESSED2 and LONG_HOLD. One counter is used; it is cleared on every state entry.
- IDLE:
  - On rise: go to PRESSED1.
- PRESSED1:
  - On fall: go to WAIT_GAP.
  - Else, if counter == LONG_PRESS_CYCLES-1: pulse o_Long and go to LONG_HOLD.
  - Else: counter++.
- WAIT_GAP:
  - On rise: pulse o_Double and go to PRESSED2.
  - Else, if counter == DOUBLE_GAP_CYCLES-1: pulse o_Short and go to IDLE.
  - Else: counter++.
- PRESSED2:
  - On fall: go to IDLE.
  - No long detection here; hold length is ignored.
- LONG_HOLD:
  - o_Held = 1.
  - On fall: go to IDLE.
  - No o_Short is emitted.
- o_Press and o_Release pulse on every rise and fall in every state, independent of classification.
- Simultaneous events:
  - A release sampled on the long-threshold edge wins: the FSM goes to WAIT_GAP with no o_Long.
  - A rise sampled on the gap-timeout edge wins: o_Double, no o_Short.
- The counter never wraps. It stops at its threshold because the state always changes there.
- Asynchronous reset, including mid-gesture:
  - State goes to IDLE and counter to 0 immediately.
  - r_Prev goes to 0.
  - All outputs go to 0 immediately.
  - No pending gesture is reported after reset.

## Timing
- All outputs are registered; pulses are exactly one cycle wide.
- Let E0 be the edge that first samples i_Button=1. o_Press is high in the cycle after E0.
- o_Long is high in the cycle after edge E0+LONG_PRESS_CYCLES, provided i_Button=1 was sampled at every edge E0..E0+LONG_PRESS_CYCLES. o_Held rises together with o_Long.
- Let F0 be the edge that first samples i_Button=0. o_Release is high in the cycle after F0.
- o_Short is high in the cycle after edge F0+DOUBLE_GAP_CYCLES if no rise is sampled at edges F0+1..F0+DOUBLE_GAP_CYCLES.
- o_Double is coincident with the second o_Press.
- o_Held falls in the same cycle that o_Release rises.
- o_Short, o_Long and o_Double are mutually exclusive per gesture; exactly one fires per gesture unless reset intervenes.

## Test plan
The bench uses LONG_PRESS_CYCLES=8, DOUBLE_GAP_CYCLES=5, with stimulus changed on falling clock edges.
- Reset:
  - Hold i_Rst_L=0 with i_Button toggling: all outputs stay 0.
  - Pull i_Rst_L low 4 cycles into a press: o_Held, o_Long and o_Short stay 0 afterwards, and the next press behaves as a first press.
- Short press: i_Button high 3 cycles, then low. Required: o_Press, then o_Release, then o_Short exactly 5 cycles after o_Release. No o_Long or o_Double.
- Long press: i_Button high 20 cycles. Required:
  - o_Long exactly 8 cycles after o_Press.
  - o_Held high from o_Long until o_Release.
  - No o_Short.
- Double press: high 3, low 2, high 3, low. Required:
  - o_Double coincident with the second o_Press.
  - Two o_Release pulses.
  - No o_Short or o_Long.
  - A second press held 20 cycles produces no o_Long and no o_Held.
- Long-threshold boundary: release sampled exactly at E0+8. Required: no o_Long; o_Short 5 cycles after o_Release.
- Gap-timeout boundary:
  - Second rise sampled at F0+5: o_Double, no o_Short.
  - Rise sampled at F0+6: o_Short, then a fresh o_Press treated as a first press.
